// File: rtl/clint_pkg.sv
// clint_pkg: FSM encoding and CLINT register map shared by the arbiter and its users
package clint_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 8;

endpackage

// File: rtl/clint_arb_rr_pick.sv
// rr_pick: rotate-priority encoder, first eligible request at or after ptr wins
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [N-1:0] elig;

    assign elig = req & mask;

    // scan farthest to nearest so the nearest eligible request overwrites earlier hits
    always_comb begin
        logic [PW-1:0] k;
        k      = '0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % N);
            if (elig[k]) begin
                onehot = N'(1) << k;
                idx    = k;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clint_arb.sv
// clint_arb: round-robin arbiter with grant locking sharing one CLINT register port
module clint_arb
    import clint_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int OFS_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ-1:0]       i_we,
    input  logic [N_REQ-1:0]       i_lock,
    input  logic [N_REQ*OFS_W-1:0] i_offset,
    input  logic [N_REQ*32-1:0]    i_wdata,
    output logic [N_REQ-1:0]       o_ack,
    output logic [31:0]            o_rdata,
    output logic [OFS_W-1:0]       o_offset,
    output logic                   o_we,
    output logic [31:0]            o_wdata,
    input  logic [31:0]            i_rdata
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("clint_arb: N_REQ must be in 2..8");
    end

    state_t           state, state_nx;
    logic [PW-1:0]    rr_ptr, g, g_inc, ptr_eff, pick_idx;
    logic [N_REQ-1:0] g_oh, mask, pick_oh;
    logic             locked, lock_hold, lock_end, pick_any, we_l;
    logic [OFS_W-1:0] ofs_l;
    logic [31:0]      wd_l;

    // while the owner keeps i_lock only it may win; releasing in IDLE rotates past it at once
    assign g_inc     = (g == PW'(N_REQ - 1)) ? '0 : g + 1'b1;
    assign lock_hold = locked && i_lock[g];
    assign lock_end  = locked && !i_lock[g];
    assign ptr_eff   = lock_end ? g_inc : rr_ptr;
    assign mask      = lock_hold ? g_oh : '1;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req    (i_req),
        .ptr    (ptr_eff),
        .mask   (mask),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // state, pointer/lock bookkeeping and the latched winning access
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            locked <= 1'b0;
            g      <= '0;
            g_oh   <= '0;
            we_l   <= 1'b0;
            ofs_l  <= '0;
            wd_l   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && lock_end) begin
                locked <= 1'b0;
                rr_ptr <= g_inc;
            end
            if (state == S_IDLE && pick_any) begin
                g     <= pick_idx;
                g_oh  <= pick_oh;
                we_l  <= i_we[pick_idx];
                ofs_l <= i_offset[pick_idx*OFS_W +: OFS_W];
                wd_l  <= i_wdata[pick_idx*32 +: 32];
            end
            if (state == S_RESP) begin
                locked <= i_lock[g];
                if (!i_lock[g]) rr_ptr <= g_inc;
            end
        end
    end

    // next state plus port drive: CLINT signals only in ISSUE, ack and read data only in RESP
    always_comb begin
        state_nx = S_IDLE;
        o_we     = 1'b0;
        o_offset = '0;
        o_wdata  = '0;
        o_ack    = '0;
        o_rdata  = '0;
        state_nx = (state == S_IDLE)  ? (pick_any ? S_ISSUE : S_IDLE) :
                   (state == S_ISSUE) ? S_RESP : S_IDLE;
        o_we     = (state == S_ISSUE) && we_l;
        o_offset = (state == S_ISSUE) ? ofs_l : '0;
        o_wdata  = (state == S_ISSUE) ? wd_l : '0;
        o_ack    = (state == S_RESP) ? g_oh : '0;
        o_rdata  = (state == S_RESP) ? i_rdata : '0;
    end

endmodule

// File: tb/tb_clint_arb.sv
// tb_clint_arb: randomized scoreboard bench for clint_arb against a transaction-level model
module tb_clint_arb;
    import clint_pkg::*;

    localparam int N  = 4;
    localparam int OW = 16;

    typedef struct {
        int             who;
        logic           we;
        logic [OW-1:0]  ofs;
        logic [31:0]    wd;
        longint         iss;
        longint         ack;
    } exp_t;

    typedef struct {
        logic           we;
        logic           lock;
        logic [OW-1:0]  ofs;
        logic [31:0]    wd;
        int             gap;
    } txn_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [N-1:0]      i_req = '0, i_we = '0, i_lock = '0;
    logic [N*OW-1:0]   i_offset = '0;
    logic [N*32-1:0]   i_wdata = '0;
    logic [31:0]       i_rdata = '0;
    logic [N-1:0]      o_ack;
    logic [31:0]       o_rdata, o_wdata;
    logic [OW-1:0]     o_offset;
    logic              o_we;

    clint_arb #(.N_REQ(N), .OFS_W(OW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .i_req    (i_req),
        .i_we     (i_we),
        .i_lock   (i_lock),
        .i_offset (i_offset),
        .i_wdata  (i_wdata),
        .o_ack    (o_ack),
        .o_rdata  (o_rdata),
        .o_offset (o_offset),
        .o_we     (o_we),
        .o_wdata  (o_wdata),
        .i_rdata  (i_rdata)
    );

    always #5 CLK = ~CLK;

    int          checks = 0, fails = 0;
    longint      cyc = 0;
    exp_t        exp_q[$];
    txn_t        tq[N][$];
    txn_t        cur[N];
    logic [N-1:0] busy = '0, ack_seen = '0;
    int          ack_log[$];
    longint      ack_cyc[$];
    logic [31:0] last_rdata = '0;
    bit          arm_rst = 0, rnd_rst = 0;

    function automatic logic [31:0] stub(input logic [OW-1:0] a);
        return (a == MTIME_LO) ? 32'h0000_1234 : {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // CLINT stand-in: registered read data, one cycle after the offset is presented
    initial begin : clint_stub
        logic [OW-1:0] s;
        forever begin
            @(negedge CLK);
            s = o_offset;
            @(posedge CLK);
            #1 i_rdata = stub(s);
        end
    end

    // reference model: arbiter is a shared resource busy for 3 cycles per access
    initial begin : model
        int     ptr, owner, pg;
        longint free_at, pend_ack;
        ptr = 0; owner = -1; pg = 0; free_at = 0; pend_ack = -1;
        forever begin
            @(posedge CLK);
            if (RST) begin
                exp_q.delete();
                ptr = 0; owner = -1; pend_ack = -1; free_at = cyc + 1;
            end else begin
                if (pend_ack == cyc) begin
                    if (i_lock[pg]) owner = pg;
                    else begin owner = -1; ptr = (pg + 1) % N; end
                end
                if (cyc >= free_at) begin
                    int g;
                    if (owner >= 0 && !i_lock[owner]) begin
                        ptr = (owner + 1) % N;
                        owner = -1;
                    end
                    g = -1;
                    for (int i = 0; i < N; i++) begin
                        int k;
                        k = (ptr + i) % N;
                        if (g < 0 && i_req[k] && (owner < 0 || owner == k)) g = k;
                    end
                    if (g >= 0) begin
                        exp_q.push_back('{g, i_we[g], i_offset[g*OW +: OW], i_wdata[g*32 +: 32], cyc + 1, cyc + 2});
                        pg = g; pend_ack = cyc + 2; free_at = cyc + 3;
                    end
                end
            end
            cyc++;
        end
    end

    // monitor: compares every cycle's outputs against the scoreboard head
    initial begin : monitor
        exp_t         e;
        logic [N-1:0] ea;
        logic         iss;
        forever begin
            @(negedge CLK);
            if (cyc >= 1) begin
                if (exp_q.size() > 0) e = exp_q[0];
                else begin e.iss = -1; e.ack = -1; e.who = 0; e.we = 0; e.ofs = '0; e.wd = '0; end
                ea  = (e.ack == cyc) ? N'(1) << e.who : '0;
                iss = (e.iss == cyc);
                chk("o_ack", 64'(o_ack), 64'(ea));
                chk("o_we", 64'(o_we), 64'(iss ? e.we : 1'b0));
                chk("o_offset", 64'(o_offset), 64'(iss ? e.ofs : '0));
                chk("o_wdata", 64'(o_wdata), 64'(iss ? e.wd : 32'h0));
                if (ea != '0) begin
                    chk("o_rdata", 64'(o_rdata), 64'(stub(e.ofs)));
                    exp_q.pop_front();
                end else chk("o_rdata idle", 64'(o_rdata), 64'h0);
                for (int j = 0; j < N; j++) if (o_ack[j]) begin
                    ack_log.push_back(j);
                    ack_cyc.push_back(cyc);
                end
                if (o_ack != '0) last_rdata = o_rdata;
                ack_seen = o_ack;
            end
        end
    end

    function automatic txn_t mk(input logic we, input logic lock, input logic [OW-1:0] ofs, input int gap);
        txn_t t;
        t.we = we; t.lock = lock; t.ofs = ofs; t.wd = $urandom; t.gap = gap;
        return t;
    endfunction

    function automatic string log_str();
        string s;
        s = "";
        foreach (ack_log[i]) s = {s, $sformatf("%0d", ack_log[i])};
        return s;
    endfunction

    function automatic string gap_str();
        string s;
        s = "";
        for (int i = 1; i < ack_cyc.size(); i++) s = {s, $sformatf("%0d", ack_cyc[i] - ack_cyc[i-1])};
        return s;
    endfunction

    function automatic bit pending();
        for (int j = 0; j < N; j++) if (tq[j].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // one cycle of requester agents: hold request until ack, then take the next queued access
    task automatic step();
        txn_t t;
        @(posedge CLK);
        #1;
        if ((arm_rst || (rnd_rst && $urandom_range(0, 15) == 0)) && o_we) begin
            arm_rst = 0;
            RST = 1'b1;
            busy = '0;
        end else RST = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (busy[j] && ack_seen[j]) busy[j] = 1'b0;
            if (!busy[j] && !RST && tq[j].size() > 0) begin
                t = tq[j][0];
                if (t.gap > 0) begin
                    t.gap--;
                    tq[j][0] = t;
                end else begin
                    cur[j] = tq[j].pop_front();
                    busy[j] = 1'b1;
                end
            end
            i_req[j]  = busy[j];
            i_lock[j] = busy[j] & cur[j].lock;
            i_we[j]   = busy[j] & cur[j].we;
            i_offset[j*OW +: OW] = busy[j] ? cur[j].ofs : '0;
            i_wdata[j*32 +: 32]  = busy[j] ? cur[j].wd : 32'h0;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && (busy != '0 || exp_q.size() > 0 || pending())) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s drain: timeout with %0d accesses outstanding, required 0", name, exp_q.size());
        end
        repeat (2) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        busy = '0; i_req = '0; i_lock = '0; i_we = '0;
        repeat (2) begin @(posedge CLK); #1; end
        RST = 1'b0;
    endtask

    task automatic clear_log();
        ack_log.delete();
        ack_cyc.delete();
        last_rdata = '0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int j = 0; j < N; j++) cur[j] = mk(1'b0, 1'b0, '0, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        clear_log();
        tq[0].push_back(mk(1'b0, 1'b0, MTIME_LO, 0));
        drain("single read", 50);
        chk_s("single read order", log_str(), "0");
        chk("single read rdata", 64'(last_rdata), 64'h1234);

        do_reset();
        clear_log();
        tq[0].push_back(mk(1'b1, 1'b0, MSIP_BASE, 0));
        tq[1].push_back(mk(1'b1, 1'b0, MSIP_BASE + 16'd4, 0));
        drain("contention", 50);
        chk_s("contention order", log_str(), "01");
        chk_s("contention spacing", gap_str(), "3");

        clear_log();
        for (int n = 0; n < 4; n++) begin
            tq[0].push_back(mk(1'b0, 1'b0, MTIMECMP_BASE, 0));
            tq[1].push_back(mk(1'b0, 1'b0, MTIMECMP_BASE + 16'd8, 0));
        end
        drain("fairness", 100);
        chk_s("fairness order", log_str(), "01010101");
        chk_s("fairness spacing", gap_str(), "3333333");

        clear_log();
        tq[1].push_back(mk(1'b1, 1'b1, MTIMECMP_BASE + 16'h8, 0));
        tq[1].push_back(mk(1'b1, 1'b1, MTIMECMP_BASE + 16'hC, 0));
        tq[0].push_back(mk(1'b0, 1'b0, MTIME_HI, 2));
        drain("lock", 100);
        chk_s("lock order", log_str(), "110");
        chk_s("lock spacing", gap_str(), "33");

        tq[2].push_back(mk(1'b0, 1'b0, MTIME_LO, 0));
        drain("ptr to 3", 50);
        clear_log();
        tq[3].push_back(mk(1'b0, 1'b0, MSIP_BASE + 16'd12, 0));
        tq[0].push_back(mk(1'b0, 1'b0, MSIP_BASE, 0));
        drain("wrap", 50);
        chk_s("wrap order", log_str(), "30");

        clear_log();
        arm_rst = 1;
        tq[2].push_back(mk(1'b1, 1'b0, MTIMECMP_BASE + 16'h10, 0));
        for (int n = 0; n < 10 && arm_rst; n++) step();
        chk("reset trigger reached ISSUE", 64'(arm_rst), 64'h0);
        arm_rst = 0;
        repeat (4) step();
        chk_s("aborted write not acked", log_str(), "");
        tq[3].push_back(mk(1'b0, 1'b0, MSIP_BASE + 16'd12, 0));
        tq[0].push_back(mk(1'b0, 1'b0, MSIP_BASE, 0));
        drain("after reset", 50);
        chk_s("pointer cleared by reset", log_str(), "03");

        rnd_rst = 1;
        for (int j = 0; j < N; j++)
            for (int n = 0; n < 50; n++)
                tq[j].push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                                   ($urandom_range(0, 3) == 0) ? 16'($urandom) : MTIMECMP_BASE + 16'(8 * j),
                                   $urandom_range(0, 3)));
        drain("random", 4000);
        rnd_rst = 0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
